multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//  Responder side of the execute-stage multi-cycle interface. Accepts MULT/MULTU/DIV/DIVU
//  launches from execute, holds the pipeline via busy, and owns the architectural HI/LO
//  registers that execute forwards into dataE. Also accepts MTHI/MTLO writes. Sits beside
//  the ALU in the execute stage; busy feeds the hazard unit.
// PARAMETERS
//  MUL_STAGES  2   multiplier pipeline depth (cycles of 64-bit product computation, >=1)
// PORTS
//  clk        in   1   clock
//  resetn     in   1   asynchronous, active-low reset
//  start      in   1   launch request (execute's is_multdiv), valid in IDLE only
//  op         in   2   multdiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
//  a, b       in   32  operands (rs, rt after forwarding); a = dividend, b = divisor
//  flush      in   1   abort in-flight op (exception/redirect)
//  stallE     in   1   execute stage held by another hazard
//  hi_we      in   1   MTHI write;  lo_we  in 1  MTLO write
//  wdata      in   32  MTHI/MTLO data
//  busy       out  1   stall request to hazard unit
//  done       out  1   one-cycle result-valid indication (level while in DONE)
//  hi, lo     out  32  architectural HI/LO
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, hi=lo=0, busy=0, done=0, counters cleared.
//  - States: IDLE, MUL, DIV, DONE.
//  - busy = (state==IDLE & start & ~flush) | state==MUL | state==DIV. Combinational, so
//    execute stalls in the launch cycle. busy=0 in DONE.
//  - IDLE + start (edge 0): latch operands and op.
//    MUL*: go to MUL.
//    DIV* with b!=0: go to DIV; latch |a|, |b| (signed) or a, b (unsigned), plus sign bits.
//    DIV* with b==0: go to DONE directly; hi/lo unchanged.
//  - MUL: 64-bit product, signed for MD_MULT, unsigned for MD_MULTU. Counter runs
//    MUL_STAGES cycles. At the edge leaving MUL: {hi,lo} <= product, state -> DONE.
//    DONE is entered MUL_STAGES+1 edges after launch.
//  - DIV: radix-2 restoring, one quotient bit per cycle, 32 iterations, then a
//    sign-fix edge. Quotient is negated if sign(a)!=sign(b); remainder takes sign of a
//    (DIV only). lo <= quotient, hi <= remainder on entering DONE (34 edges after launch).
//  - DONE: done=1.
//    stallE=1: stay in DONE; start is ignored (no relaunch of the same instr).
//    stallE=0: go to IDLE next edge.
//  - flush (any state): next state IDLE, in-flight result discarded, hi/lo unchanged.
//    busy drops the same cycle. A flush coincident with the final edge also discards
//    (flush wins).
//  - MTHI/MTLO: hi_we/lo_we update hi/lo at the edge, only when state is IDLE or DONE.
//    Asserting while busy is illegal (assertion). The update applies in IDLE/DONE only,
//    and flush does not cancel it.
//  - -2^31 / -1 (DIV): lo=32'h8000_0000, hi=0; no exception.
//  - start in MUL/DIV is ignored. op must be stable only in the launch cycle.
// STRUCTURE
//  - Shared package: multdiv_op_t enum (2 bits) and the multdiv state enum. DIV_ITERS=32.
//  - Sub-module div_iter: unsigned 32/32 restoring divider with start/count/quotient/
//    remainder. Sign handling and the MUL pipeline stay in multdiv_unit.
// TESTING
//  1. MULT a=-3, b=5 -> DONE at edge MUL_STAGES+1: hi=FFFF_FFFF, lo=FFFF_FFF1; busy high
//     through edge MUL_STAGES.
//  2. DIVU a=100, b=7 -> DONE at edge 34: lo=14, hi=2. DIV a=-7, b=2 -> lo=FFFF_FFFD,
//     hi=FFFF_FFFF.
//  3. DIV a=5, b=0 with hi=lo=0xA5A5_A5A5 -> DONE at edge 1; hi/lo unchanged; busy only
//     in the launch cycle.
//  4. DIVU launched, flush at cycle 10 -> busy=0 that cycle, IDLE next, hi/lo unchanged.
//     MULTU 2x3 launched next -> lo=6.
//  5. MULTU done while stallE=1 for 3 cycles with start held -> exactly one result
//     write, no relaunch; IDLE after stallE falls.
//  6. resetn low mid-DIV -> immediate IDLE, hi=lo=0, busy=0. Also MTLO 0x1234 in IDLE ->
//     lo=0x1234 next edge.

Source files
------------

// File: rtl/multdiv_unit_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide unit.
//   multdiv_op_t    : launch opcode carried on the execute interface
//   multdiv_state_t : multdiv_unit FSM state encoding
//   DIV_ITERS       : quotient bits produced by the iterative divider
package multdiv_unit_pkg;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } multdiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } multdiv_state_t;

    function automatic logic op_is_div(input multdiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input multdiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Magnitude of a two's-complement value when en is set; -2^31 maps to
    // 32'h8000_0000, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Execute <-> multdiv_unit interface.
//   master (execute): start, op, a, b, flush, stallE, hi_we, lo_we, wdata
//   slave  (multdiv_unit): busy, done, hi, lo
interface multdiv_unit_if;
    import multdiv_unit_pkg::*;

    logic        start;
    multdiv_op_t op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stallE;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, stallE, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, stallE, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/multdiv_unit_div_iter.sv
// Unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle.
//   clk, resetn : clock, async active-low reset
//   start       : load dividend/divisor and begin DIV_ITERS iterations
//   dividend    : numerator (unsigned)
//   divisor     : denominator (unsigned, nonzero)
//   count       : iterations remaining; 0 means quotient/remainder are final
//   quotient    : unsigned quotient
//   remainder   : unsigned remainder
module multdiv_unit_div_iter
    import multdiv_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [31:0]          dividend,
    input  logic [31:0]          divisor,
    output logic [DIV_CNT_W-1:0] count,
    output logic [31:0]          quotient,
    output logic [31:0]          remainder
);

    logic [31:0]          rem_q;
    logic [31:0]          quo_q;
    logic [31:0]          dvs_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [32:0]          shifted;
    logic [32:0]          trial;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while quotient bits fill in from the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= DIV_CNT_W'(DIV_ITERS);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_CNT_W'(1);
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign count     = cnt_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/multdiv_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
//   clk, resetn : clock, async active-low reset
//   md (slave)  : launch (start/op/a/b), flush, stallE, MTHI/MTLO writes;
//                 returns busy (combinational stall request), done, hi, lo
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a launch; MTHI/MTLO accepted
//   ST_MUL  | product in flight, MUL_STAGES cycles, busy
//   ST_DIV  | 32 divider iterations then one sign-fix edge, busy
//   ST_DONE | result visible, done=1; held while stallE, MTHI/MTLO accepted
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    multdiv_unit_if.slave  md
);

    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    multdiv_state_t       state_q;
    logic [MCW-1:0]       mul_cnt_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic                 signed_q;
    logic                 quo_neg_q;
    logic                 rem_neg_q;
    logic [31:0]          hi_q;
    logic [31:0]          lo_q;

    logic                 launch;
    logic                 launch_div;
    logic                 launch_signed;
    logic [63:0]          mul_x;
    logic [63:0]          mul_y;
    logic [63:0]          product;
    logic [DIV_CNT_W-1:0] div_count;
    logic [31:0]          div_quo;
    logic [31:0]          div_rem;
    logic [31:0]          quo_fix;
    logic [31:0]          rem_fix;

    assign launch        = (state_q == ST_IDLE) && md.start && !md.flush;
    assign launch_signed = op_is_signed(md.op);
    assign launch_div    = launch && op_is_div(md.op) && (md.b != 32'd0);

    multdiv_unit_div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (launch_div),
        .dividend  (abs32(md.a, launch_signed)),
        .divisor   (abs32(md.b, launch_signed)),
        .count     (div_count),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Extending to 64 bits and keeping the low half of the product gives the
    // correct two's-complement result for both signed and unsigned operands.
    assign mul_x   = {{32{signed_q & a_q[31]}}, a_q};
    assign mul_y   = {{32{signed_q & b_q[31]}}, b_q};
    assign product = mul_x * mul_y;

    assign quo_fix = quo_neg_q ? (32'd0 - div_quo) : div_quo;
    assign rem_fix = rem_neg_q ? (32'd0 - div_rem) : div_rem;

    // Flush drops the stall request in the same cycle so the redirect is not held.
    assign md.busy = launch || (!md.flush && ((state_q == ST_MUL) || (state_q == ST_DIV)));
    assign md.done = (state_q == ST_DONE);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // MTHI/MTLO land regardless of a coincident flush.
            if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
                if (md.hi_we) hi_q <= md.wdata;
                if (md.lo_we) lo_q <= md.wdata;
            end

            if (md.flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (md.start) begin
                            a_q       <= md.a;
                            b_q       <= md.b;
                            signed_q  <= launch_signed;
                            quo_neg_q <= launch_signed && (md.a[31] ^ md.b[31]);
                            rem_neg_q <= launch_signed && md.a[31];
                            mul_cnt_q <= MCW'(MUL_STAGES - 1);
                            if (!op_is_div(md.op))   state_q <= ST_MUL;
                            else if (md.b != 32'd0)  state_q <= ST_DIV;
                            else                     state_q <= ST_DONE;
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt_q == '0) begin
                            {hi_q, lo_q} <= product;
                            state_q      <= ST_DONE;
                        end else begin
                            mul_cnt_q <= mul_cnt_q - MCW'(1);
                        end
                    end
                    ST_DIV: begin
                        if (div_count == '0) begin
                            lo_q    <= quo_fix;
                            hi_q    <= rem_fix;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (!md.stallE) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    hi_lo_write_when_idle: assert property (
        @(posedge clk) disable iff (!resetn) !((md.hi_we || md.lo_we) && md.busy)
    );

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    localparam int MS = 2;
    localparam int MUL_LAT = MS + 1;
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    multdiv_unit_if md();

    multdiv_unit #(.MUL_STAGES(MS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (md)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        multdiv_op_t op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Launch one op with stallE low, count edges (launch edge = 1) until done,
    // then confirm the unit returns to IDLE on the following edge.
    task automatic run_op(input string name, input multdiv_op_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        #1 chk({name, "_busy_launch"}, md.busy, 1);
        @(posedge clk);
        #1 md.start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            if (md.done) begin
                seen = 1'b1;
            end else begin
                chk({name, "_busy_run"}, md.busy, 1);
                @(posedge clk);
                #1 lat++;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_done"}, md.busy, 0);
        chk({name, "_hi"}, md.hi, exp_hi);
        chk({name, "_lo"}, md.lo, exp_lo);
        @(posedge clk);
        #1 chk({name, "_back_idle"}, md.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        md.start  = 1'b0;
        md.op     = MD_MULT;
        md.a      = '0;
        md.b      = '0;
        md.flush  = 1'b0;
        md.stallE = 1'b0;
        md.hi_we  = 1'b0;
        md.lo_we  = 1'b0;
        md.wdata  = '0;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[2]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{MD_MULT,  32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, MUL_LAT};
        vecs[4]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,         32'd14,        DIV_LAT};
        vecs[5]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
        vecs[7]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};
        vecs[8]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'd2,        32'd1,         32'h7FFF_FFFF, DIV_LAT};
        vecs[9]  = '{MD_DIVU,  32'd5,        32'd10,       32'd5,         32'd0,         DIV_LAT};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         DIV_LAT};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", md.hi, 0);
        chk("reset_lo", md.lo, 0);
        chk("reset_busy", md.busy, 0);
        chk("reset_done", md.done, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven arithmetic
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        // MTHI/MTLO then divide by zero: DONE on the launch edge, hi/lo untouched
        @(negedge clk);
        md.hi_we = 1'b1;
        md.lo_we = 1'b1;
        md.wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        md.hi_we = 1'b0;
        md.lo_we = 1'b0;
        chk("mthi_a5", md.hi, 32'hA5A5_A5A5);
        chk("mtlo_a5", md.lo, 32'hA5A5_A5A5);
        run_op("div0", MD_DIV, 32'd5, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1);

        // Flush mid-divide
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_DIVU;
        md.a     = 32'd1000;
        md.b     = 32'd3;
        @(posedge clk);
        #1 md.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        md.flush = 1'b1;
        #1 chk("flush_busy_drop", md.busy, 0);
        @(posedge clk);
        #1;
        md.flush = 1'b0;
        chk("flush_idle_done", md.done, 0);
        chk("flush_idle_busy", md.busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_late_done", md.done, 0);
        chk("flush_hi_kept", md.hi, 32'hA5A5_A5A5);
        chk("flush_lo_kept", md.lo, 32'hA5A5_A5A5);
        run_op("after_flush_multu", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MUL_LAT);

        // Flush coincident with the final MUL edge discards the product
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_MULT;
        md.a     = 32'd3;
        md.b     = 32'd3;
        @(posedge clk);
        #1 md.start = 1'b0;
        repeat (MS - 1) @(posedge clk);
        @(negedge clk);
        md.flush = 1'b1;
        @(posedge clk);
        #1;
        md.flush = 1'b0;
        chk("flush_final_done", md.done, 0);
        chk("flush_final_lo", md.lo, 32'd6);
        chk("flush_final_hi", md.hi, 32'd0);

        // DONE held by stallE with start held: single result, no relaunch
        @(negedge clk);
        md.stallE = 1'b1;
        md.start  = 1'b1;
        md.op     = MD_MULTU;
        md.a      = 32'd4;
        md.b      = 32'd5;
        @(posedge clk);
        repeat (MS) @(posedge clk);
        #1;
        chk("stall_done", md.done, 1);
        chk("stall_lo", md.lo, 32'd20);
        @(negedge clk);
        md.a = 32'd6;
        md.b = 32'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_hold_done%0d", k), md.done, 1);
            chk($sformatf("stall_hold_busy%0d", k), md.busy, 0);
            chk($sformatf("stall_hold_lo%0d", k), md.lo, 32'd20);
        end
        @(negedge clk);
        md.hi_we = 1'b1;
        md.wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        md.hi_we = 1'b0;
        chk("mthi_in_done", md.hi, 32'h0000_BEEF);
        chk("mthi_in_done_state", md.done, 1);
        @(negedge clk);
        md.stallE = 1'b0;
        md.start  = 1'b0;
        @(posedge clk);
        #1 chk("stall_release_idle", md.done, 0);
        @(posedge clk);
        #1;
        chk("stall_no_relaunch_busy", md.busy, 0);
        chk("stall_no_relaunch_lo", md.lo, 32'd20);

        // Reset asserted mid-divide
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_DIV;
        md.a     = 32'd50;
        md.b     = 32'd7;
        @(posedge clk);
        #1 md.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_hi", md.hi, 0);
        chk("rst_mid_lo", md.lo, 0);
        chk("rst_mid_busy", md.busy, 0);
        chk("rst_mid_done", md.done, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_mid_stays_idle", md.done, 0);

        // MTLO in IDLE
        @(negedge clk);
        md.lo_we = 1'b1;
        md.wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        md.lo_we = 1'b0;
        chk("mtlo_idle_lo", md.lo, 32'h0000_1234);
        chk("mtlo_idle_hi", md.hi, 32'd0);

        run_op("post_reset_multu", MD_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'd1, 32'd0, MUL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
